// File: rtl/line_reader_if.sv
// ---------------------------------------------------------------------------
// line_reader_if
// Bundles every non-clock signal of the line reader.
//   Line control : LINE_READY, LINE_BANK, FRAME_SYNC, CLR_OVERRUN (to reader)
//                  BUSY, OVERRUN (from reader)
//   Buffer read  : RD_EN, RD_BANK, RD_ADDR (from reader), RD_DATA (to reader,
//                  valid one cycle after RD_EN)
//   Pixel stream : PIX_DATA, PIX_VALID, PIX_SOL, PIX_EOL, PIX_SOF (from reader)
//                  PIX_READY (to reader)
// modport master : the line reader itself
// modport slave  : the surrounding buffer / downstream / control logic
// ---------------------------------------------------------------------------
interface line_reader_if #(
  parameter int ADC_WIDHT    = 14,
  parameter int NUMB_CHAN    = 2,
  parameter int PIX_PER_CHAN = 320
);
  localparam int AW = (PIX_PER_CHAN > 1) ? $clog2(PIX_PER_CHAN) : 1;

  logic                           LINE_READY;
  logic                           LINE_BANK;
  logic                           FRAME_SYNC;
  logic                           CLR_OVERRUN;
  logic                           RD_EN;
  logic                           RD_BANK;
  logic [AW-1:0]                  RD_ADDR;
  logic [NUMB_CHAN*ADC_WIDHT-1:0] RD_DATA;
  logic [ADC_WIDHT-1:0]           PIX_DATA;
  logic                           PIX_VALID;
  logic                           PIX_READY;
  logic                           PIX_SOL;
  logic                           PIX_EOL;
  logic                           PIX_SOF;
  logic                           BUSY;
  logic                           OVERRUN;

  modport master (
    input  LINE_READY, LINE_BANK, FRAME_SYNC, CLR_OVERRUN, RD_DATA, PIX_READY,
    output RD_EN, RD_BANK, RD_ADDR, PIX_DATA, PIX_VALID, PIX_SOL, PIX_EOL,
           PIX_SOF, BUSY, OVERRUN
  );

  modport slave (
    output LINE_READY, LINE_BANK, FRAME_SYNC, CLR_OVERRUN, RD_DATA, PIX_READY,
    input  RD_EN, RD_BANK, RD_ADDR, PIX_DATA, PIX_VALID, PIX_SOL, PIX_EOL,
           PIX_SOF, BUSY, OVERRUN
  );
endinterface

// File: rtl/line_reader.sv
// ---------------------------------------------------------------------------
// line_reader
// Read-side controller for the ping-pong per-channel ADC line buffers. When a
// line completes in one bank it fetches that bank word by word (one sample per
// channel per word) and emits the channels interleaved as a single pixel
// stream with valid/ready handshake and SOL/EOL/SOF markers.
//   CLK      : single clock
//   RESET_N  : synchronous active-low reset
//   bus      : line_reader_if.master (line control, buffer read port, pixel
//              stream, BUSY/OVERRUN status)
// Word order: word0 ch0, word0 ch1, ..., word1 ch0, ...
// A one-word prefetch register keeps the stream bubble-free: the read of word
// a+1 is issued in the same cycle word a enters the holding register.
// ---------------------------------------------------------------------------
module line_reader #(
  parameter int ADC_WIDHT       = 14,
  parameter int NUMB_CHAN       = 2,
  parameter int PIX_PER_CHAN    = 320,
  parameter int LINES_PER_FRAME = 240
) (
  input  logic          CLK,
  input  logic          RESET_N,
  line_reader_if.master bus
);

  localparam int WW = NUMB_CHAN * ADC_WIDHT;
  localparam int AW = (PIX_PER_CHAN > 1)    ? $clog2(PIX_PER_CHAN)    : 1;
  localparam int CW = (NUMB_CHAN > 1)       ? $clog2(NUMB_CHAN)       : 1;
  localparam int LW = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;

  localparam logic [AW-1:0] LAST_ADDR = AW'(PIX_PER_CHAN - 1);
  localparam logic [CW-1:0] LAST_CHAN = CW'(NUMB_CHAN - 1);
  localparam logic [LW-1:0] LAST_LINE = LW'(LINES_PER_FRAME - 1);
  localparam logic [AW:0]   ADDR_END  = (AW+1)'(PIX_PER_CHAN);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    FILL,
    STREAM,
    DONE
  } state_t;

  state_t state, state_nxt;

  // Control state (reset)
  logic          rd_bank;
  logic [AW-1:0] addr_last;
  logic          pend_p0;
  logic          vld_p0;
  logic          vld_p1;
  logic [AW-1:0] word_p1;
  logic [CW-1:0] chan_p1;
  logic [LW-1:0] line_cnt;
  logic          sync_pend;
  logic          overrun;

  // Data state (no reset; qualified by the valid flags)
  logic [WW-1:0] pref_p0;
  logic [WW-1:0] hold_p1;

  // Combinational controls
  logic          busy;
  logic          xfer;
  logic          last_chan;
  logic          last_word;
  logic          load_hold;
  logic          load_from_pref;
  logic [AW-1:0] load_word;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   next_ext;

  function automatic logic [ADC_WIDHT-1:0] chan_sel(input logic [WW-1:0] word,
                                                    input logic [CW-1:0] ch);
    logic [ADC_WIDHT-1:0] r;
    r = '0;
    for (int k = 0; k < NUMB_CHAN; k++) begin
      if (ch == CW'(k)) r = word[k*ADC_WIDHT +: ADC_WIDHT];
    end
    return r;
  endfunction

  assign busy      = (state != IDLE);
  assign xfer      = vld_p1 && bus.PIX_READY;
  assign last_chan = (chan_p1 == LAST_CHAN);
  assign last_word = (word_p1 == LAST_ADDR);

  always_comb begin
    state_nxt      = state;
    load_hold      = 1'b0;
    load_from_pref = 1'b0;
    load_word      = word_p1;
    rd_en          = 1'b0;
    rd_addr        = addr_last;
    next_ext       = '0;

    case (state)
      IDLE: begin
        if (bus.LINE_READY) state_nxt = FETCH;
      end
      FETCH: begin
        rd_en     = 1'b1;
        rd_addr   = '0;
        state_nxt = FILL;
      end
      FILL: begin
        load_hold = 1'b1;
        load_word = '0;
        state_nxt = STREAM;
      end
      STREAM: begin
        if (xfer && last_chan && last_word) begin
          state_nxt = DONE;
        end else if (vld_p0 && (!vld_p1 || (xfer && last_chan))) begin
          // Holding register is empty or releasing its last channel this
          // cycle: move the prefetched word in without a bubble.
          load_hold      = 1'b1;
          load_from_pref = 1'b1;
          load_word      = word_p1 + AW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Each word load launches exactly one read for the following word, so
    // no address is ever requested twice within a line.
    if (load_hold) begin
      next_ext = {1'b0, load_word} + (AW+1)'(1);
      if (next_ext < ADDR_END) begin
        rd_en   = 1'b1;
        rd_addr = next_ext[AW-1:0];
      end
    end
  end

  // ---- stage p0: read request / prefetch register ----
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state     <= IDLE;
      rd_bank   <= 1'b0;
      addr_last <= '0;
      pend_p0   <= 1'b0;
      vld_p0    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.LINE_READY) rd_bank <= bus.LINE_BANK;
      if (rd_en) addr_last <= rd_addr;
      // The FETCH read is consumed directly by FILL, not by the prefetch.
      pend_p0 <= rd_en && (state != FETCH);
      if (pend_p0) begin
        vld_p0 <= 1'b1;
      end else if (load_from_pref) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (pend_p0) pref_p0 <= bus.RD_DATA;
  end

  // ---- stage p1: holding register / pixel output ----
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      vld_p1  <= 1'b0;
      word_p1 <= '0;
      chan_p1 <= '0;
    end else begin
      if (load_hold) begin
        vld_p1  <= 1'b1;
        word_p1 <= load_word;
        chan_p1 <= '0;
      end else if (xfer) begin
        if (last_chan) begin
          vld_p1 <= 1'b0;
        end else begin
          chan_p1 <= chan_p1 + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (load_hold) hold_p1 <= load_from_pref ? pref_p0 : bus.RD_DATA;
  end

  // Line counter, deferred frame sync and sticky overrun
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      line_cnt  <= '0;
      sync_pend <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A sync coinciding with LINE_READY makes the starting line line 0.
          if (bus.FRAME_SYNC) line_cnt <= '0;
          sync_pend <= 1'b0;
        end
        DONE: begin
          if (bus.FRAME_SYNC || sync_pend) begin
            line_cnt <= '0;
          end else if (line_cnt == LAST_LINE) begin
            line_cnt <= '0;
          end else begin
            line_cnt <= line_cnt + LW'(1);
          end
          sync_pend <= 1'b0;
        end
        default: begin
          if (bus.FRAME_SYNC) sync_pend <= 1'b1;
        end
      endcase

      // A new line arriving while busy (DONE included) is dropped; set wins
      // over a coincident clear.
      if (bus.LINE_READY && busy) begin
        overrun <= 1'b1;
      end else if (bus.CLR_OVERRUN) begin
        overrun <= 1'b0;
      end
    end
  end

  assign bus.RD_EN     = rd_en;
  assign bus.RD_BANK   = rd_bank;
  assign bus.RD_ADDR   = rd_addr;
  assign bus.PIX_VALID = vld_p1;
  assign bus.PIX_DATA  = vld_p1 ? chan_sel(hold_p1, chan_p1) : '0;
  assign bus.PIX_SOL   = vld_p1 && (word_p1 == '0) && (chan_p1 == '0);
  assign bus.PIX_EOL   = vld_p1 && last_word && last_chan;
  assign bus.PIX_SOF   = bus.PIX_SOL && (line_cnt == '0);
  assign bus.BUSY      = busy;
  assign bus.OVERRUN   = overrun;

endmodule

// File: tb/tb_line_reader.sv
// ---------------------------------------------------------------------------
// tb_line_reader
// Self-checking bench for line_reader (NUMB_CHAN=2, PIX_PER_CHAN=4,
// LINES_PER_FRAME=3). The buffer returns ch0=0x100+a, ch1=0x200+a for word a,
// one cycle after RD_EN, and random garbage otherwise. A behavioural model
// tracks line acceptance, the expected pixel sequence (queue), line numbering,
// frame sync and overrun, and is compared against the DUT every cycle.
// ---------------------------------------------------------------------------
module tb_line_reader;
  localparam int ADC_WIDHT       = 14;
  localparam int NUMB_CHAN       = 2;
  localparam int PIX_PER_CHAN    = 4;
  localparam int LINES_PER_FRAME = 3;
  localparam int NPIX            = NUMB_CHAN * PIX_PER_CHAN;
  localparam int WW              = NUMB_CHAN * ADC_WIDHT;

  typedef struct packed {
    logic [ADC_WIDHT-1:0] d;
    logic                 sol;
    logic                 eol;
    logic                 sof;
  } pix_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   ready_mode = 0;

  line_reader_if #(
    .ADC_WIDHT(ADC_WIDHT), .NUMB_CHAN(NUMB_CHAN), .PIX_PER_CHAN(PIX_PER_CHAN)
  ) bus ();

  line_reader #(
    .ADC_WIDHT(ADC_WIDHT), .NUMB_CHAN(NUMB_CHAN),
    .PIX_PER_CHAN(PIX_PER_CHAN), .LINES_PER_FRAME(LINES_PER_FRAME)
  ) dut (
    .CLK(clk),
    .RESET_N(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Buffer memory: answers the read one cycle after RD_EN.
  initial begin
    logic          en;
    logic [1:0]    a;
    bus.RD_DATA = '0;
    forever begin
      @(negedge clk);
      en = bus.RD_EN;
      a  = bus.RD_ADDR;
      @(posedge clk);
      #1;
      if (en) bus.RD_DATA = {ADC_WIDHT'(32'h200 + a), ADC_WIDHT'(32'h100 + a)};
      else    bus.RD_DATA = WW'($urandom);
    end
  end

  // Downstream ready pattern: 0 = always ready, 1 = toggle, 2 = random.
  initial begin
    bus.PIX_READY = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.PIX_READY = 1'b1;
        1:       bus.PIX_READY = !bus.PIX_READY;
        default: bus.PIX_READY = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- reference model ----------------
  pix_t exq[$];
  logic live = 1'b0;
  logic m_busy = 1'b0, m_done = 1'b0, m_ovr = 1'b0, m_sync = 1'b0, m_bank = 1'b0;
  int   m_age = 0, m_left = 0, m_line = 0, rd_cnt = 0;
  logic seen [PIX_PER_CHAN];
  logic p_valid = 1'b0, p_ready = 1'b0;
  logic [ADC_WIDHT+2:0] p_out = '0;
  logic line_end;
  pix_t e;

  always @(negedge clk) begin
    if (live) begin
      chk_val("busy", bus.BUSY, m_busy);
      chk_val("overrun", bus.OVERRUN, m_ovr);
      if (!m_busy || m_done || m_age < 3) chk_val("valid_idle", bus.PIX_VALID, 0);
      else if (m_left > 0)                chk_val("no_bubble", bus.PIX_VALID, 1);
      if (m_busy && m_age == 1)
        chk_val("first_rd", {bus.RD_EN, bus.RD_BANK, bus.RD_ADDR}, {1'b1, m_bank, 2'd0});
      if (bus.RD_EN) begin
        chk_val("rd_when_busy", m_busy && !m_done, 1);
        chk_val("rd_bank", bus.RD_BANK, m_bank);
        chk_val("rd_repeat", seen[bus.RD_ADDR], 0);
        seen[bus.RD_ADDR] = 1'b1;
        rd_cnt++;
      end
      if (m_done) chk_val("rd_count", rd_cnt, PIX_PER_CHAN);
      if (p_valid && !p_ready) begin
        chk_val("stall_valid", bus.PIX_VALID, 1);
        chk_val("stall_hold", {bus.PIX_DATA, bus.PIX_SOL, bus.PIX_EOL, bus.PIX_SOF}, p_out);
      end
      line_end = 1'b0;
      if (bus.PIX_VALID && bus.PIX_READY) begin
        if (exq.size() == 0) begin
          chk_val("xfer_unexpected", exq.size(), 1);
        end else begin
          e = exq.pop_front();
          chk_val("pix_data", bus.PIX_DATA, e.d);
          chk_val("pix_marks", {bus.PIX_SOL, bus.PIX_EOL, bus.PIX_SOF}, {e.sol, e.eol, e.sof});
          m_left--;
          if (m_left == 0) line_end = 1'b1;
        end
      end
      p_valid = bus.PIX_VALID;
      p_ready = bus.PIX_READY;
      p_out   = {bus.PIX_DATA, bus.PIX_SOL, bus.PIX_EOL, bus.PIX_SOF};
    end

    // advance the model to the next cycle using this cycle's inputs
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_ovr = 0; m_sync = 0; m_bank = 0;
      m_age = 0; m_left = 0; m_line = 0; rd_cnt = 0;
      exq.delete();
      p_valid = 0;
      live = 1'b1;
    end else if (live) begin
      if (bus.LINE_READY && m_busy) m_ovr = 1'b1;
      else if (bus.CLR_OVERRUN)     m_ovr = 1'b0;
      if (m_done) begin
        m_done = 0;
        m_busy = 0;
        m_line = (m_sync || bus.FRAME_SYNC) ? 0 : (m_line + 1) % LINES_PER_FRAME;
        m_sync = 0;
      end else if (m_busy) begin
        if (bus.FRAME_SYNC) m_sync = 1'b1;
        if (line_end) m_done = 1'b1;
      end else begin
        if (bus.FRAME_SYNC) m_line = 0;
        if (bus.LINE_READY) begin
          m_busy = 1'b1;
          m_bank = bus.LINE_BANK;
          m_age  = 0;
          m_left = NPIX;
          rd_cnt = 0;
          for (int a = 0; a < PIX_PER_CHAN; a++) seen[a] = 1'b0;
          for (int i = 0; i < NPIX; i++) begin
            e.d   = ADC_WIDHT'(32'h100 * (i % NUMB_CHAN + 1) + i / NUMB_CHAN);
            e.sol = (i == 0);
            e.eol = (i == NPIX - 1);
            e.sof = (i == 0) && (m_line == 0);
            exq.push_back(e);
          end
        end
      end
      m_age++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_line(input logic bank);
    bus.LINE_READY = 1'b1;
    bus.LINE_BANK  = bank;
    tick();
    bus.LINE_READY = 1'b0;
  endtask

  task automatic pulse_sync();
    bus.FRAME_SYNC = 1'b1;
    tick();
    bus.FRAME_SYNC = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_busy || exq.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    chk_val("idle_timeout", n < 300, 1);
  endtask

  initial begin
    bus.LINE_READY  = 1'b0;
    bus.LINE_BANK   = 1'b0;
    bus.FRAME_SYNC  = 1'b0;
    bus.CLR_OVERRUN = 1'b0;

    // reset, then idle
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_val("reset_outs",
            {bus.RD_EN, bus.RD_BANK, bus.RD_ADDR, bus.PIX_DATA, bus.PIX_VALID,
             bus.PIX_SOL, bus.PIX_EOL, bus.PIX_SOF, bus.BUSY, bus.OVERRUN}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) tick();

    // single line, continuous ready, bank 1
    ready_mode = 0;
    start_line(1'b1);
    wait_idle();

    // backpressure: ready toggles
    ready_mode = 1;
    start_line(1'b0);
    wait_idle();
    ready_mode = 0;
    tick();

    // frame wrap: 4 lines from line 0, then sync mid line 1
    pulse_sync();
    for (int l = 0; l < 4; l++) begin
      start_line(l[0]);
      wait_idle();
    end
    pulse_sync();
    start_line(1'b0);
    wait_idle();
    start_line(1'b1);
    repeat (5) tick();
    pulse_sync();
    wait_idle();
    start_line(1'b0);
    wait_idle();

    // sync coinciding with LINE_READY in idle
    bus.FRAME_SYNC = 1'b1;
    start_line(1'b1);
    bus.FRAME_SYNC = 1'b0;
    wait_idle();

    // overrun, set-wins-over-clear, then clear
    ready_mode = 1;
    start_line(1'b0);
    repeat (3) tick();
    start_line(1'b1);
    repeat (3) tick();
    bus.CLR_OVERRUN = 1'b1;
    start_line(1'b1);
    bus.CLR_OVERRUN = 1'b0;
    wait_idle();
    bus.CLR_OVERRUN = 1'b1;
    tick();
    bus.CLR_OVERRUN = 1'b0;
    ready_mode = 0;
    repeat (2) tick();

    // reset mid-line after pixel 3
    start_line(1'b1);
    begin
      int n = 0;
      while (m_left > NPIX - 4 && n < 50) begin
        tick();
        n++;
      end
      chk_val("mid_timeout", n < 50, 1);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    start_line(1'b0);
    wait_idle();

    // randomized traffic
    ready_mode = 2;
    for (int c = 0; c < 1500; c++) begin
      bus.LINE_READY  = ($urandom_range(0, 11) == 0);
      bus.LINE_BANK   = 1'($urandom_range(0, 1));
      bus.FRAME_SYNC  = ($urandom_range(0, 19) == 0);
      bus.CLR_OVERRUN = ($urandom_range(0, 9) == 0);
      tick();
    end
    bus.LINE_READY  = 1'b0;
    bus.FRAME_SYNC  = 1'b0;
    bus.CLR_OVERRUN = 1'b0;
    wait_idle();
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
